// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-side master for sync_fifo_counter. Waits until the FIFO holds a full
//   burst, or until a partial burst has sat in the FIFO long enough, then
//   reads the burst out and forwards it on a valid/ready stream with a
//   last-word marker. A 3-entry skid buffer absorbs the FIFO's one-cycle
//   read latency and any downstream backpressure.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   empty      FIFO empty flag
//   fcounter   FIFO occupancy
//   r_data     FIFO read data, valid the cycle after r_enable
//   r_enable   FIFO read strobe
//   out_data   downstream word (head of the skid buffer)
//   out_valid  out_data is valid
//   out_ready  downstream accepts on out_valid && out_ready
//   out_last   final word of the current burst
//   busy       high whenever not IDLE
//   cur_len    length of the active burst, 0 in IDLE
//   burst_cnt  completed bursts, wraps at 2^16
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 512,
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        empty,
  input  logic [$clog2(DATA_DEPTH):0] fcounter,
  input  logic [DATA_WIDTH-1:0]       r_data,
  output logic                        r_enable,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy,
  output logic [$clog2(DATA_DEPTH):0] cur_len,
  output logic [15:0]                 burst_cnt
);

  localparam int CW = $clog2(DATA_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] BurstLenC   = CW'(BURST_LEN);
  localparam logic [TW-1:0] TimeoutMaxC = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         curLen_q;
  logic [CW-1:0]         issued_q;
  logic [CW-1:0]         delivered_q;
  logic [TW-1:0]         timeout_q;
  logic [15:0]           burstCnt_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] skid_q [3];
  logic [1:0]            rdPtr_q;
  logic [1:0]            wrPtr_q;
  logic [1:0]            occ_q;

  logic startFull;
  logic startPartial;
  logic push;
  logic pop;
  logic lastPop;
  logic issueDone;

  // Skid buffer pointers run modulo 3.
  function automatic logic [1:0] ptrNext(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A full burst always wins over a timed-out partial one.
  assign startFull    = (state_q == IDLE) && (fcounter >= BurstLenC);
  assign startPartial = (state_q == IDLE) && !startFull && !empty &&
                        (timeout_q == TimeoutMaxC);
  assign push         = inflight_q;
  assign pop          = out_valid && out_ready;
  assign lastPop      = (state_q == DRAIN) && pop && out_last;
  assign issueDone    = r_enable && ((issued_q + CW'(1)) == curLen_q);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> READ on a burst start, READ -> DRAIN once the
  // last read is issued, DRAIN -> IDLE on the pop of the last word.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (startFull || startPartial) state_d = READ;
      READ:    if (issueDone) state_d = DRAIN;
      DRAIN:   if (lastPop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. The read strobe looks only at registered state and the FIFO
  // flags; limiting occ + inflight to 2 before a new read guarantees the
  // returning word always has a free skid slot.
  always_comb begin
    r_enable  = 1'b0;
    if ((state_q == READ) && (issued_q < curLen_q) && !empty &&
        (({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2)) begin
      r_enable = 1'b1;
    end
    busy      = (state_q != IDLE);
    out_valid = (occ_q != 2'd0);
    out_data  = out_valid ? skid_q[rdPtr_q] : '0;
    out_last  = out_valid && (delivered_q == (curLen_q - CW'(1)));
    cur_len   = curLen_q;
    burst_cnt = burstCnt_q;
  end

  // Datapath: burst bookkeeping, timeout counter and skid buffer. Clearing
  // inflight on reset drops any word returning from a pre-reset read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      curLen_q    <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      timeout_q   <= '0;
      burstCnt_q  <= '0;
      inflight_q  <= 1'b0;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      occ_q       <= '0;
      for (int i = 0; i < 3; i++) begin
        skid_q[i] <= '0;
      end
    end else begin
      inflight_q <= r_enable;

      // The timeout only counts while idling on a non-empty FIFO; reaching
      // TimeoutMaxC starts a burst, so it never passes that value.
      if ((state_q == IDLE) && !startFull && !startPartial && !empty) begin
        timeout_q <= timeout_q + TW'(1);
      end else begin
        timeout_q <= '0;
      end

      if (startFull) begin
        curLen_q <= BurstLenC;
      end else if (startPartial) begin
        curLen_q <= fcounter;
      end else if (lastPop) begin
        curLen_q <= '0;
      end

      if (lastPop) begin
        issued_q <= '0;
      end else if (r_enable) begin
        issued_q <= issued_q + CW'(1);
      end

      if (lastPop) begin
        delivered_q <= '0;
      end else if (pop) begin
        delivered_q <= delivered_q + CW'(1);
      end

      if (lastPop) begin
        burstCnt_q <= burstCnt_q + 16'd1;
      end

      if (push) begin
        skid_q[wrPtr_q] <= r_data;
        wrPtr_q         <= ptrNext(wrPtr_q);
      end
      if (pop) begin
        rdPtr_q <= ptrNext(rdPtr_q);
      end

      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader
//   Directed bench for fifo_burst_reader. Instance A uses the default
//   parameters (BURST_LEN 16, TIMEOUT 64); instance B uses BURST_LEN 1.
//   Each instance is fed by a small queue-based model of sync_fifo_counter
//   with one-cycle read latency. Inputs change 1 time unit after the rising
//   edge; outputs are observed on the falling edge.
module tb_fifo_burst_reader;

  logic clk = 1'b0;
  logic reset = 1'b0;

  // Instance A signals
  logic       emptyA;
  logic [9:0] fcounterA = '0;
  logic [7:0] rDataA = '0;
  logic       rEnA;
  logic [7:0] outDataA;
  logic       outValidA;
  logic       outReadyA = 1'b1;
  logic       outLastA;
  logic       busyA;
  logic [9:0] curLenA;
  logic [15:0] burstCntA;
  logic       wrEnA = 1'b0;
  logic [7:0] wrDataA = '0;
  logic       fifoClrA = 1'b0;
  logic [7:0] fifoA[$];

  // Instance B signals
  logic       emptyB;
  logic [9:0] fcounterB = '0;
  logic [7:0] rDataB = '0;
  logic       rEnB;
  logic [7:0] outDataB;
  logic       outValidB;
  logic       outReadyB = 1'b1;
  logic       outLastB;
  logic       busyB;
  logic [9:0] curLenB;
  logic [15:0] burstCntB;
  logic       wrEnB = 1'b0;
  logic [7:0] wrDataB = '0;
  logic [7:0] fifoB[$];

  // Bookkeeping
  int assertCount = 0;
  int failCount = 0;
  int emptyReadA = 0;
  int emptyReadB = 0;
  int cycA = 0;
  int firstWrA, firstRenA, rdCntA, issuedTotA, poppedTotA;
  int outstandViolA, stableViolA, curLenSeenA;
  bit seenBusyA, prevStallA;
  logic [7:0] prevDataA;
  logic [7:0] popDataA[$];
  bit         popLastA[$];
  int         popCycA[$];
  logic [7:0] popDataB[$];
  bit         popLastB[$];
  int gapViolB = 0;
  bit idleSeenB = 1'b0;

  fifo_burst_reader dutA (
    .clk(clk), .reset(reset), .empty(emptyA), .fcounter(fcounterA),
    .r_data(rDataA), .r_enable(rEnA), .out_data(outDataA),
    .out_valid(outValidA), .out_ready(outReadyA), .out_last(outLastA),
    .busy(busyA), .cur_len(curLenA), .burst_cnt(burstCntA)
  );

  fifo_burst_reader #(.BURST_LEN(1)) dutB (
    .clk(clk), .reset(reset), .empty(emptyB), .fcounter(fcounterB),
    .r_data(rDataB), .r_enable(rEnB), .out_data(outDataB),
    .out_valid(outValidB), .out_ready(outReadyB), .out_last(outLastB),
    .busy(busyB), .cur_len(curLenB), .burst_cnt(burstCntB)
  );

  always #5 clk = ~clk;

  assign emptyA = (fcounterA == 10'd0);
  assign emptyB = (fcounterB == 10'd0);

  // FIFO model A: read data appears the cycle after the strobe.
  initial forever begin
    @(posedge clk);
    if (rEnA) begin
      if (fifoA.size() == 0) emptyReadA++;
      else rDataA <= fifoA.pop_front();
    end
    if (fifoClrA) fifoA.delete();
    if (wrEnA) fifoA.push_back(wrDataA);
    fcounterA <= 10'(fifoA.size());
  end

  // FIFO model B.
  initial forever begin
    @(posedge clk);
    if (rEnB) begin
      if (fifoB.size() == 0) emptyReadB++;
      else rDataB <= fifoB.pop_front();
    end
    if (wrEnB) fifoB.push_back(wrDataB);
    fcounterB <= 10'(fifoB.size());
  end

  // Monitor A: records every handshake, read counts, outstanding reads and
  // stability of a stalled word.
  initial forever begin
    @(negedge clk);
    cycA++;
    if (!reset) begin
      prevStallA = 1'b0;
    end else begin
      if (wrEnA && firstWrA < 0) firstWrA = cycA;
      if (rEnA) begin
        rdCntA++;
        issuedTotA++;
        if (firstRenA < 0) firstRenA = cycA;
      end
      if (issuedTotA - poppedTotA > 3) outstandViolA++;
      if (prevStallA && (!outValidA || outDataA !== prevDataA)) stableViolA++;
      if (busyA && !seenBusyA) begin
        seenBusyA   = 1'b1;
        curLenSeenA = int'(curLenA);
      end
      if (outValidA && outReadyA) begin
        popDataA.push_back(outDataA);
        popLastA.push_back(outLastA);
        popCycA.push_back(cycA);
        poppedTotA++;
      end
      prevStallA = outValidA && !outReadyA;
      prevDataA  = outDataA;
    end
  end

  // Monitor B: handshakes and at least one idle cycle between bursts.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (!busyB) idleSeenB = 1'b1;
      if (outValidB && outReadyB) begin
        if (popDataB.size() > 0 && !idleSeenB) gapViolB++;
        popDataB.push_back(outDataB);
        popLastB.push_back(outLastB);
        idleSeenB = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearMonA();
    firstWrA = -1; firstRenA = -1; rdCntA = 0; issuedTotA = 0; poppedTotA = 0;
    outstandViolA = 0; stableViolA = 0; curLenSeenA = -1;
    seenBusyA = 1'b0; prevStallA = 1'b0;
    popDataA.delete(); popLastA.delete(); popCycA.delete();
  endtask

  // Writes count sequential words starting at firstVal, one per cycle.
  task automatic applyStimulus(input int count, input int firstVal, input bit toB);
    for (int i = 0; i < count; i++) begin
      @(posedge clk); #1;
      if (toB) begin
        wrEnB = 1'b1; wrDataB = 8'(firstVal + i);
      end else begin
        wrEnA = 1'b1; wrDataA = 8'(firstVal + i);
      end
    end
    @(posedge clk); #1;
    wrEnA = 1'b0;
    wrEnB = 1'b0;
  endtask

  task automatic waitBurstA(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (burstCntA == 16'(target)) break;
    end
  endtask

  // Compares recorded handshakes with sequential data and a last marker at
  // the end of every burstLen words.
  task automatic checkPopsA(input string tag, input int n, input int firstVal,
                            input int burstLen);
    int dataErr = 0;
    int lastErr = 0;
    checkOutput({tag, "_count"}, popDataA.size(), n);
    for (int k = 0; k < popDataA.size(); k++) begin
      if (popDataA[k] !== 8'(firstVal + k)) dataErr++;
      if (popLastA[k] != ((k % burstLen) == burstLen - 1)) lastErr++;
    end
    checkOutput({tag, "_data_errors"}, dataErr, 0);
    checkOutput({tag, "_last_errors"}, lastErr, 0);
  endtask

  initial begin
    clearMonA();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_r_enable", rEnA, 0);
    checkOutput("rst_out_valid", outValidA, 0);
    checkOutput("rst_out_last", outLastA, 0);
    checkOutput("rst_out_data", outDataA, 0);
    checkOutput("rst_busy", busyA, 0);
    checkOutput("rst_cur_len", curLenA, 0);
    checkOutput("rst_burst_cnt", burstCntA, 0);

    // Test 1: one full burst with the sink always ready.
    @(posedge clk); #1;
    reset = 1'b1;
    clearMonA();
    applyStimulus(16, 'h01, 1'b0);
    waitBurstA(1, 200);
    checkOutput("t1_burst_cnt", burstCntA, 1);
    checkOutput("t1_busy", busyA, 0);
    checkOutput("t1_reads", rdCntA, 16);
    checkOutput("t1_cur_len", curLenSeenA, 16);
    checkOutput("t1_start_latency", firstRenA - firstWrA, 17);
    checkOutput("t1_first_word_latency", popCycA[0] - firstRenA, 2);
    checkOutput("t1_back_to_back", popCycA[15] - popCycA[0], 15);
    checkPopsA("t1", 16, 'h01, 16);
    checkOutput("t1_fcounter", fcounterA, 0);

    // Test 2: partial burst flushed by the timeout.
    @(posedge clk); #1;
    clearMonA();
    applyStimulus(5, 'h21, 1'b0);
    waitBurstA(2, 300);
    checkOutput("t2_burst_cnt", burstCntA, 2);
    checkOutput("t2_timeout_delay", firstRenA - firstWrA, 65);
    checkOutput("t2_cur_len", curLenSeenA, 5);
    checkOutput("t2_reads", rdCntA, 5);
    checkPopsA("t2", 5, 'h21, 5);

    // Test 3: full FIFO drained with out_ready toggling every cycle.
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(512, 0, 1'b0);
    @(negedge clk);
    checkOutput("t3_fcounter_full", fcounterA, 512);
    @(posedge clk); #1;
    reset = 1'b1;
    clearMonA();
    outReadyA = 1'b1;
    for (int i = 0; i < 4000 && burstCntA != 16'd32; i++) begin
      outReadyA = ~outReadyA;
      @(posedge clk); #1;
    end
    outReadyA = 1'b1;
    @(negedge clk);
    checkOutput("t3_burst_cnt", burstCntA, 32);
    checkOutput("t3_fcounter_end", fcounterA, 0);
    checkOutput("t3_reads", rdCntA, 512);
    checkOutput("t3_outstanding_over_3", outstandViolA, 0);
    checkOutput("t3_unstable_stall", stableViolA, 0);
    checkPopsA("t3", 512, 0, 16);

    // Test 4: sink blocked at the start of a full burst.
    @(posedge clk); #1;
    clearMonA();
    outReadyA = 1'b0;
    applyStimulus(16, 'h41, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("t4_reads_stalled", rdCntA, 3);
    checkOutput("t4_r_enable_low", rEnA, 0);
    checkOutput("t4_valid_held", outValidA, 1);
    checkOutput("t4_data_held", outDataA, 'h41);
    @(posedge clk); #1;
    outReadyA = 1'b1;
    waitBurstA(33, 200);
    checkOutput("t4_burst_cnt", burstCntA, 33);
    checkOutput("t4_reads", rdCntA, 16);
    checkOutput("t4_unstable_stall", stableViolA, 0);
    checkPopsA("t4", 16, 'h41, 16);

    // Test 5: reset (with a FIFO reset) after the 7th word is delivered.
    @(posedge clk); #1;
    clearMonA();
    applyStimulus(16, 'h61, 1'b0);
    for (int i = 0; i < 200 && popDataA.size() < 7; i++) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    outReadyA = 1'b0;
    fifoClrA = 1'b1;
    @(posedge clk); #1;
    fifoClrA = 1'b0;
    @(negedge clk);
    checkOutput("t5_out_valid", outValidA, 0);
    checkOutput("t5_busy", busyA, 0);
    checkOutput("t5_cur_len", curLenA, 0);
    checkOutput("t5_burst_cnt", burstCntA, 0);
    checkOutput("t5_words_before_reset", popDataA.size(), 7);
    @(posedge clk); #1;
    reset = 1'b1;
    outReadyA = 1'b1;
    clearMonA();
    applyStimulus(16, 'h81, 1'b0);
    waitBurstA(1, 200);
    checkOutput("t5_burst_cnt_after", burstCntA, 1);
    checkPopsA("t5", 16, 'h81, 16);

    // Test 6: BURST_LEN 1 instance, three single-word bursts.
    @(posedge clk); #1;
    applyStimulus(3, 'hC1, 1'b1);
    for (int i = 0; i < 100 && burstCntB != 16'd3; i++) @(negedge clk);
    checkOutput("t6_burst_cnt", burstCntB, 3);
    checkOutput("t6_count", popDataB.size(), 3);
    for (int k = 0; k < popDataB.size(); k++) begin
      checkOutput($sformatf("t6_data%0d", k), popDataB[k], 8'(('hC1) + k));
      checkOutput($sformatf("t6_last%0d", k), popLastB[k], 1);
    end
    checkOutput("t6_no_idle_gap", gapViolB, 0);
    checkOutput("t6_busy", busyB, 0);

    checkOutput("read_of_empty_fifo_A", emptyReadA, 0);
    checkOutput("read_of_empty_fifo_B", emptyReadB, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side master for sync_fifo_counter. It drains the FIFO in bursts and presents the words downstream on a valid/ready stream with a last-word marker. A burst starts when the FIFO holds a full burst, or when a partial burst has been waiting past a timeout. The block absorbs the FIFO's one-cycle read latency and downstream backpressure with an internal 3-entry skid buffer.

Parameters:
DATA_WIDTH, 8, word width; matches the FIFO.
DATA_DEPTH, 512, FIFO depth; fcounter width is $clog2(DATA_DEPTH)+1.
BURST_LEN, 16, words per full burst; legal range 1..DATA_DEPTH.
TIMEOUT, 64, idle cycles with a non-empty FIFO before a partial burst is flushed; legal range >=1.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-low reset.
empty  input  1  FIFO empty flag.
fcounter  input  $clog2(DATA_DEPTH)+1  FIFO occupancy.
r_data  input  DATA_WIDTH  FIFO read data; valid the cycle after an accepted r_enable.
r_enable  output  1  FIFO read strobe.
out_data  output  DATA_WIDTH  downstream data.
out_valid  output  1  out_data is valid.
out_ready  input  1  downstream accepts the word when out_valid && out_ready.
out_last  output  1  marks the final word of the current burst; qualified by out_valid.
busy  output  1  high whenever the state is not IDLE.
cur_len  output  $clog2(DATA_DEPTH)+1  length of the active burst; 0 in IDLE.
burst_cnt  output  16  number of completed bursts; wraps modulo 2^16.

Behaviour:
- Reset (reset==0 at a clk edge) has priority over everything else.
  - Effects: state=IDLE; r_enable=0; out_valid=0; out_last=0; out_data=0; busy=0; cur_len=0; burst_cnt=0.
  - Clears the skid buffer, the in-flight flag, the issue and delivery counters, and the timeout counter.
  - Data returned for a read issued before reset is discarded.
- State IDLE:
  - If fcounter >= BURST_LEN: latch cur_len=BURST_LEN and go to READ. The timeout counter clears.
  - Else if !empty and the timeout counter == TIMEOUT-1: latch cur_len=fcounter and go to READ. This is a partial burst.
  - Else if !empty: the timeout counter increments.
  - Else (empty): the timeout counter clears.
  - The full-burst condition wins when both conditions hold.
- State READ: r_enable=1 only when all of the following hold.
  - issued < cur_len.
  - !empty.
  - occ + inflight <= 2, where occ is the skid-buffer occupancy (0..3) and inflight is the r_enable of the previous cycle.
  - r_enable depends only on registered state, empty and fcounter. It never depends combinationally on out_ready.
  - Transition: when issued reaches cur_len, go to DRAIN.
- Capture:
  - When inflight==1, r_data is pushed into the skid buffer at the end of that cycle.
  - The buffer never overflows, by construction of the r_enable condition.
- Output:
  - out_valid = occ > 0; out_data is the head of the buffer.
  - A word pops on out_valid && out_ready.
  - A push and a pop in the same cycle are both honoured.
  - out_last = out_valid && (delivered == cur_len-1).
- State DRAIN: on the pop where out_last=1:
  - burst_cnt increments;
  - cur_len, issued and delivered clear;
  - state goes to IDLE.
  - The block re-evaluates burst start from the following cycle (one IDLE cycle minimum between bursts).
- Throughput: with out_ready held at 1, a BURST_LEN burst delivers one word per cycle after a 2-cycle start latency.
  - Cycle 0: IDLE decision.
  - Cycle 1: first r_enable.
  - Cycle 2: r_data captured.
  - Cycle 3: first out_valid.
- Empty mid-burst: can occur only with an external reset of the FIFO. r_enable stays low while empty and the burst resumes when data returns; the block never reads an empty FIFO.
- Backpressure: out_valid and out_data stay stable while out_ready=0. Reads stall once occ + inflight reaches 3.
- Widths: issued and delivered are $clog2(DATA_DEPTH)+1 bits. The timeout counter is $clog2(TIMEOUT)+1 bits and saturates at TIMEOUT-1 only in IDLE.

Test Plan:
1. Reset, then write 16 words 0x01..0x10 with out_ready=1:
   - r_enable pulses 16 cycles;
   - out_data sequence 0x01..0x10 on consecutive cycles;
   - out_last only with 0x10;
   - burst_cnt=1; busy back to 0.
2. Write 5 words, then idle with out_ready=1:
   - no read for 63 cycles;
   - partial burst with cur_len=5;
   - 5 words out, out_last on the 5th; burst_cnt increments.
3. Fill the FIFO to 512, toggle out_ready 1/0 every cycle:
   - 32 bursts of 16 words, data order preserved, no word lost or duplicated;
   - never more than 3 reads outstanding; out_data stable while stalled;
   - burst_cnt=32, fcounter ends at 0.
4. out_ready=0 for 20 cycles at the start of a full burst:
   - exactly 3 r_enable pulses, then r_enable=0;
   - on release, the remaining 13 reads resume and data order is intact.
5. Assert reset mid-burst after word 7 is delivered:
   - next cycle out_valid=0, busy=0, cur_len=0, burst_cnt=0;
   - no stale word appears after reset.
6. BURST_LEN=1, write 3 words:
   - three 1-word bursts, each with out_last=1;
   - at least one IDLE cycle between bursts; burst_cnt=3.
